// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//   Iterative AES-128 encryption sequencer. It accepts one plaintext block,
//   applies the initial AddRoundKey itself, then drives a shared external
//   round datapath ten times: nine full rounds and one last round without
//   MixColumns. Round keys come from a synchronous round-key store. The
//   ciphertext is presented on a valid/ready handshake.
//
//   State table:
//     state  | meaning
//     IDLE   | ready for a plaintext block
//     KEY    | rk_data holds key[round_cnt]; round 0 is the local whitening
//     WAIT   | round operands presented; waiting ROUND_LAT cycles for result
//     DONE   | ciphertext valid, waiting for out_ready
//
//   Parameters:
//     ROUND_LAT    cycles rnd_result needs after the first WAIT cycle
//                  (datapath register stages + 1), legal range 1..15
//
//   Optional build macro:
//     AES_CTRL_PERF_EN  adds output blk_cnt[31:0], counting output handshakes
//
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     in_valid/in_ready/in_data    plaintext handshake
//     rk_addr/rk_data              round-key store address (registered) / key
//     rnd_start                    one-cycle pulse, new round operands
//     rnd_last                     high for the whole WAIT of round 10
//     rnd_data_out/rnd_key_out     round operands (registered, held in WAIT)
//     rnd_result                   datapath result
//     out_valid/out_ready/out_data ciphertext handshake
//     blk_cnt                      completed blocks (AES_CTRL_PERF_EN only)
//     busy                         high in every state except IDLE
//     round_cnt                    current round 0..10
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int unsigned ROUND_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         rnd_start,
  output logic         rnd_last,
  output logic [127:0] rnd_data_out,
  output logic [127:0] rnd_key_out,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_CTRL_PERF_EN
  output logic [31:0]  blk_cnt,
`endif
  output logic         busy,
  output logic [3:0]   round_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_LAST_ROUND = 4'd10;
  localparam logic [3:0] LP_WAIT_INIT  = 4'(ROUND_LAT - 1);

  state_t         r_fsm;
  state_t         w_fsm_nxt;
  logic [127:0]   r_state;
  logic [127:0]   r_key;
  logic [3:0]     r_rk_addr;
  logic [3:0]     r_round;
  logic [3:0]     r_wait;
  logic           r_start;
  logic           r_last;
  logic           w_accept;
  logic           w_wait_done;

  // Next-state and handshake decode
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_accept    = 1'b0;
    w_wait_done = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept  = 1'b1;
          w_fsm_nxt = S_KEY;
        end
      end
      S_KEY: begin
        // Round 0 whitening stays in KEY for one more cycle to fetch key[1]
        if (r_round != 4'd0) begin
          w_fsm_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait == 4'd0) begin
          w_wait_done = 1'b1;
          w_fsm_nxt   = (r_round == LP_LAST_ROUND) ? S_DONE : S_KEY;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= '0;
      r_key     <= '0;
      r_rk_addr <= '0;
      r_round   <= '0;
      r_wait    <= '0;
      r_start   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= in_data;
            r_rk_addr <= 4'd0;
            r_round   <= 4'd0;
          end
        end
        S_KEY: begin
          if (r_round == 4'd0) begin
            r_state   <= r_state ^ rk_data;
            r_round   <= 4'd1;
            r_rk_addr <= 4'd1;
          end else begin
            r_key   <= rk_data;
            r_wait  <= LP_WAIT_INIT;
            r_start <= 1'b1;
            r_last  <= (r_round == LP_LAST_ROUND);
          end
        end
        S_WAIT: begin
          if (!w_wait_done) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_state <= rnd_result;
            if (r_round == LP_LAST_ROUND) begin
              r_last <= 1'b0;
            end else begin
              r_round   <= r_round + 4'd1;
              r_rk_addr <= r_round + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef AES_CTRL_PERF_EN
  logic [31:0] r_blk_cnt;
  logic        w_out_hs;

  assign w_out_hs = out_valid & out_ready;

  // Free-running count; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt <= '0;
    end else if (w_out_hs) begin
      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

  assign rk_addr      = r_rk_addr;
  assign round_cnt    = r_round;
  assign rnd_start    = r_start;
  assign rnd_last     = r_last;
  // The state register only changes at the end of WAIT, so it serves directly
  // as the held round operand and as the ciphertext.
  assign rnd_data_out = r_state;
  assign rnd_key_out  = r_key;
  assign out_data     = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//   Directed bench for aes_round_ctrl. dut0 uses ROUND_LAT = 3 with a
//   two-register-stage behavioural round datapath; dut1 uses ROUND_LAT = 1
//   with a combinational datapath. Both read a behavioural round-key store
//   that expands the selected AES-128 key.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  int n_vec  = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [127:0] tb_key = KEY_C1;

  // dut0 signals
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         rnd_start;
  logic         rnd_last;
  logic [127:0] rnd_data_out;
  logic [127:0] rnd_key_out;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_cnt;

  // dut1 signals
  logic         d1_in_valid = 1'b0;
  logic         d1_in_ready;
  logic [127:0] d1_in_data = '0;
  logic [3:0]   d1_rk_addr;
  logic [127:0] d1_rk_data;
  logic         d1_rnd_start;
  logic         d1_rnd_last;
  logic [127:0] d1_rnd_data_out;
  logic [127:0] d1_rnd_key_out;
  logic [127:0] d1_rnd_result;
  logic         d1_out_valid;
  logic         d1_out_ready = 1'b0;
  logic [127:0] d1_out_data;
  logic         d1_busy;
  logic [3:0]   d1_round_cnt;
`ifdef AES_CTRL_PERF_EN
  logic [31:0]  blk_cnt;
  logic [31:0]  d1_blk_cnt;
`endif

  aes_round_ctrl #(.ROUND_LAT(3)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_addr(rk_addr), .rk_data(rk_data),
    .rnd_start(rnd_start), .rnd_last(rnd_last),
    .rnd_data_out(rnd_data_out), .rnd_key_out(rnd_key_out),
    .rnd_result(rnd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_CTRL_PERF_EN
    .blk_cnt(blk_cnt),
`endif
    .busy(busy), .round_cnt(round_cnt)
  );

  aes_round_ctrl #(.ROUND_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .rk_addr(d1_rk_addr), .rk_data(d1_rk_data),
    .rnd_start(d1_rnd_start), .rnd_last(d1_rnd_last),
    .rnd_data_out(d1_rnd_data_out), .rnd_key_out(d1_rnd_key_out),
    .rnd_result(d1_rnd_result),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
`ifdef AES_CTRL_PERF_EN
    .blk_cnt(d1_blk_cnt),
`endif
    .busy(d1_busy), .round_cnt(d1_round_cnt)
  );

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as x^254, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq = x;
    logic [7:0] inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st,
                                             input logic [127:0] key,
                                             input logic last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int n = 0; n < 16; n++) s[n] = sbox(st[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = s[r + 4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = t[n];
    return res ^ key;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input logic [3:0] idx);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon = 8'h01;
    int          k = int'(idx);
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        tmp = tmp ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    if (k > 10) return '0;
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  // Round-key store: data for the registered address is valid in the cycle
  // after the address register updates.
  assign rk_data    = round_key(tb_key, rk_addr);
  assign d1_rk_data = round_key(KEY_C1, d1_rk_addr);

  // dut0 datapath: two register stages (ROUND_LAT = 3)
  logic [127:0] p1 = '0;
  logic [127:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= aes_round(rnd_data_out, rnd_key_out, rnd_last);
    p2 <= p1;
  end
  assign rnd_result = p2;

  // dut1 datapath: combinational (ROUND_LAT = 1)
  assign d1_rnd_result = aes_round(d1_rnd_data_out, d1_rnd_key_out, d1_rnd_last);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_vec++; if (rk_addr !== 4'd0) begin n_fail++; $display("FAIL reset rk_addr: got %0d want 0", rk_addr); end
    n_vec++; if (round_cnt !== 4'd0) begin n_fail++; $display("FAIL reset round_cnt: got %0d want 0", round_cnt); end
    n_vec++; if (rnd_start !== 1'b0 || rnd_last !== 1'b0) begin n_fail++; $display("FAIL reset rnd_start/rnd_last: got %b/%b want 0/0", rnd_start, rnd_last); end
    n_vec++; if (rnd_key_out !== 128'h0) begin n_fail++; $display("FAIL reset rnd_key_out: got %h want 0", rnd_key_out); end
    n_vec++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset out_data: got %h want 0", out_data); end
`ifdef AES_CTRL_PERF_EN
    n_vec++; if (blk_cnt !== 32'd0) begin n_fail++; $display("FAIL reset blk_cnt: got %0d want 0", blk_cnt); end
`endif
  endtask

  task automatic test_fips_c1();
    int cyc = 1;
    int n_start = 0;
    int n_last = 0;
    bit addr_bad = 0, last_bad = 0, ir_bad = 0;
    logic [3:0] last_addr;
    out_ready = 1'b1;
    in_data = PT_C1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    last_addr = rk_addr;
    n_vec++; if (rk_addr !== 4'd0) begin n_fail++; $display("FAIL c1 first rk_addr: got %0d want 0", rk_addr); end
    while (!out_valid && cyc < 200) begin
      if (rk_addr !== last_addr) begin
        if (rk_addr !== last_addr + 4'd1) addr_bad = 1;
        last_addr = rk_addr;
      end
      if (rk_addr > 4'd10) addr_bad = 1;
      if (in_ready) ir_bad = 1;
      if (rnd_start) n_start++;
      if (rnd_last) begin
        n_last++;
        if (round_cnt !== 4'd10) last_bad = 1;
      end
      tick();
      cyc++;
    end
    n_vec++; if (cyc != 42) begin n_fail++; $display("FAIL c1 latency: got %0d want 42", cyc); end
    n_vec++; if (out_data !== CT_C1) begin n_fail++; $display("FAIL c1 out_data: got %h want %h", out_data, CT_C1); end
    n_vec++; if (addr_bad || last_addr !== 4'd10) begin n_fail++; $display("FAIL c1 rk_addr sequence: last %0d bad %0d want 10/0", last_addr, addr_bad); end
    n_vec++; if (n_start != 10) begin n_fail++; $display("FAIL c1 rnd_start pulses: got %0d want 10", n_start); end
    n_vec++; if (n_last != 3 || last_bad) begin n_fail++; $display("FAIL c1 rnd_last cycles: got %0d (bad %0d) want 3", n_last, last_bad); end
    n_vec++; if (ir_bad) begin n_fail++; $display("FAIL c1 in_ready while busy: got 1 want 0"); end
    n_vec++; if (rnd_last !== 1'b0 || round_cnt !== 4'd10) begin n_fail++; $display("FAIL c1 done rnd_last/round_cnt: got %b/%0d want 0/10", rnd_last, round_cnt); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL c1 return idle: out_valid %b in_ready %b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_stall();
    int cyc = 1;
    bit hold_bad = 0;
    out_ready = 1'b0;
    in_data = PT_C1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && cyc < 200) begin tick(); cyc++; end
    n_vec++; if (cyc != 42) begin n_fail++; $display("FAIL stall latency: got %0d want 42", cyc); end
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_data !== CT_C1 || in_ready !== 1'b0 || busy !== 1'b1)
        hold_bad = 1;
      in_valid = (i % 2 == 0);
      in_data = PT_B;
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (hold_bad) begin n_fail++; $display("FAIL stall hold: outputs changed during stall, want stable"); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== CT_C1) begin n_fail++; $display("FAIL stall end: out_valid %b out_data %h want 1/%h", out_valid, out_data, CT_C1); end
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall release: out_valid %b busy %b in_ready %b want 0/0/1", out_valid, busy, in_ready); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    out_ready = 1'b1;
    in_data = PT_C1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (round_cnt !== 4'd5 && cyc < 100) begin tick(); cyc++; end
    n_vec++; if (round_cnt !== 4'd5) begin n_fail++; $display("FAIL rstmid reach round 5: got %0d want 5", round_cnt); end
    rst = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid idle: busy %b out_valid %b in_ready %b want 0/0/1", busy, out_valid, in_ready); end
    n_vec++; if (round_cnt !== 4'd0 || rk_addr !== 4'd0 || rnd_start !== 1'b0) begin n_fail++; $display("FAIL rstmid regs: round_cnt %0d rk_addr %0d rnd_start %b want 0/0/0", round_cnt, rk_addr, rnd_start); end
    rst = 1'b0;
    tick();
    tb_key = KEY_B;
    in_data = PT_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin tick(); cyc++; end
    n_vec++; if (cyc != 42) begin n_fail++; $display("FAIL rstmid fresh latency: got %0d want 42", cyc); end
    n_vec++; if (out_data !== CT_B) begin n_fail++; $display("FAIL rstmid fresh out_data: got %h want %h", out_data, CT_B); end
    tick();
    tb_key = KEY_C1;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int n_acc = 0, n_done = 0;
    int acc [2];
    int done [2];
    bit data_bad = 0;
    acc = '{-1, -1}; done = '{-1, -1};
    out_ready = 1'b1;
    in_data = PT_C1; in_valid = 1'b1;
    while (n_done < 2 && cyc < 300) begin
      if (in_ready && n_acc < 2) begin acc[n_acc] = cyc; n_acc++; end
      if (out_valid) begin
        if (out_data !== CT_C1) data_bad = 1;
        done[n_done] = cyc; n_done++;
      end
      if (n_done < 2) begin
        tick();
        cyc++;
        if (n_acc == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_vec++; if (acc[0] != 0 || done[0] != 42) begin n_fail++; $display("FAIL b2b first: accept %0d done %0d want 0/42", acc[0], done[0]); end
    n_vec++; if (acc[1] != 43) begin n_fail++; $display("FAIL b2b second accept: got %0d want 43", acc[1]); end
    n_vec++; if (done[1] != 85) begin n_fail++; $display("FAIL b2b second done: got %0d want 85", done[1]); end
    n_vec++; if (data_bad) begin n_fail++; $display("FAIL b2b ciphertext: a block differed from %h", CT_C1); end
    tick();
  endtask

  task automatic test_lat1();
    int cyc;
    int n_start;
    int n_last;
    bit ir_bad;
    d1_out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      n_start = 0; n_last = 0; ir_bad = 0;
      d1_in_data = PT_C1; d1_in_valid = 1'b1;
      tick();
      d1_in_valid = 1'b0;
      cyc = 1;
      while (!d1_out_valid && cyc < 100) begin
        if (d1_rnd_start) n_start++;
        if (d1_rnd_last) n_last++;
        if (d1_in_ready) ir_bad = 1;
        tick();
        cyc++;
      end
      n_vec++; if (cyc != 22) begin n_fail++; $display("FAIL lat1 latency blk%0d: got %0d want 22", b, cyc); end
      n_vec++; if (d1_out_data !== CT_C1) begin n_fail++; $display("FAIL lat1 out_data blk%0d: got %h want %h", b, d1_out_data, CT_C1); end
      n_vec++; if (n_start != 10 || n_last != 1 || ir_bad) begin n_fail++; $display("FAIL lat1 pulses blk%0d: start %0d last %0d ir %0d want 10/1/0", b, n_start, n_last, ir_bad); end
      n_vec++; if (d1_busy !== 1'b1 || d1_round_cnt !== 4'd10) begin n_fail++; $display("FAIL lat1 done state blk%0d: busy %b round_cnt %0d want 1/10", b, d1_busy, d1_round_cnt); end
      tick();
    end
`ifdef AES_CTRL_PERF_EN
    n_vec++; if (d1_blk_cnt !== 32'd2) begin n_fail++; $display("FAIL lat1 blk_cnt: got %0d want 2", d1_blk_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_lat1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
